// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ps2_key toggle decode plus joystick OR into registered per-player control words; autofire under `AUTOFIRE_EN`.
// Latency: joystick 1 cycle, keyboard event 2 cycles; coin output stretched to at least COIN_PULSE cycles.
// Backpressure: none; every ps2 toggle and joystick sample is consumed in the cycle it arrives.
module arcade_input_mapper #(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 3,
  parameter int COIN_PULSE = 16,
  parameter int AF_PERIOD  = 4096
) (
  input  logic                           clk_sys,
  input  logic                           reset_n,
  input  logic [10:0]                    ps2_key,
  input  logic [PLAYERS*(BUTTONS+7)-1:0] joystick,
  input  logic [PLAYERS*BUTTONS-1:0]     autofire_sel,
  output logic [PLAYERS*(BUTTONS+7)-1:0] player,
  output logic [1:0]                     service
);
  localparam int P  = BUTTONS + 7;
  localparam int KP = (PLAYERS < 2) ? PLAYERS : 2;
  localparam int CW = $clog2(COIN_PULSE + 1);

  logic            tog_q, tog_d;
  logic            primed_q, primed_d;
  logic [KP*P-1:0] key_q, key_d;
  logic [1:0]      svc_q, svc_d;
  logic [1:0]      service_q, service_d;
  logic [2*P-1:0]  key_hit;
  logic [1:0]      svc_hit;
  logic            ps2_evt;

  // Keymap: one-hot hit mask over both keyboard players' vectors.
  always_comb begin
    key_hit = '0;
    svc_hit = '0;
    case (ps2_key[7:0])
      8'h75: if (ps2_key[8]) key_hit[3] = 1'b1;
      8'h72: if (ps2_key[8]) key_hit[2] = 1'b1;
      8'h6B: if (ps2_key[8]) key_hit[1] = 1'b1;
      8'h74: if (ps2_key[8]) key_hit[0] = 1'b1;
      8'h14: key_hit[4] = 1'b1;
      8'h11: if (BUTTONS > 1) key_hit[5] = 1'b1;
      8'h29: if (BUTTONS > 2) key_hit[6] = 1'b1;
      8'h16: key_hit[4+BUTTONS] = 1'b1;
      8'h2E: key_hit[5+BUTTONS] = 1'b1;
      8'h4D: key_hit[6+BUTTONS] = 1'b1;
      8'h2D: key_hit[P+3] = 1'b1;
      8'h2B: key_hit[P+2] = 1'b1;
      8'h23: key_hit[P+1] = 1'b1;
      8'h34: key_hit[P+0] = 1'b1;
      8'h1C: key_hit[P+4] = 1'b1;
      8'h1B: if (BUTTONS > 1) key_hit[P+5] = 1'b1;
      8'h15: if (BUTTONS > 2) key_hit[P+6] = 1'b1;
      8'h1E: key_hit[P+4+BUTTONS] = 1'b1;
      8'h36: key_hit[P+5+BUTTONS] = 1'b1;
      8'h46: svc_hit[0] = 1'b1;
      8'h45: svc_hit[1] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ps2_evt  = primed_q && (ps2_key[10] != tog_q);
    primed_d = 1'b1;
    // Priming and event both capture the toggle; otherwise it already equals tog_q.
    tog_d    = ps2_key[10];
    key_d    = key_q;
    svc_d    = svc_q;
    if (ps2_evt) begin
      key_d = (key_q & ~key_hit[KP*P-1:0]) | (key_hit[KP*P-1:0] & {(KP*P){ps2_key[9]}});
      svc_d = (svc_q & ~svc_hit) | (svc_hit & {2{ps2_key[9]}});
    end
    service_d = svc_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q     <= 1'b0;
      primed_q  <= 1'b0;
      key_q     <= '0;
      svc_q     <= '0;
      service_q <= '0;
    end else begin
      tog_q     <= tog_d;
      primed_q  <= primed_d;
      key_q     <= key_d;
      svc_q     <= svc_d;
      service_q <= service_d;
    end
  end

  assign service = service_q;

  if (KP < 2) begin : g_one_kbd
    logic unused_p2_hit;
    assign unused_p2_hit = ^key_hit[2*P-1:P];
  end

`ifdef AUTOFIRE_EN
  localparam int AW = $clog2(AF_PERIOD);
  logic [AW-1:0] af_cnt_q, af_cnt_d;
  logic          af_phase_q, af_phase_d;

  always_comb begin
    af_cnt_d   = af_cnt_q + AW'(1);
    af_phase_d = af_phase_q;
    if (af_cnt_q == AW'(AF_PERIOD - 1)) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end
`else
  logic unused_af;
  assign unused_af = ^autofire_sel ^ AF_PERIOD[0];
`endif

  for (genvar g = 0; g < PLAYERS; g++) begin : g_plr
    logic [P-1:0]  kbd, raw, out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          coin_prev_q, coin_prev_d;
    logic          coin_start;

    if (g < KP) begin : g_kbd
      assign kbd = key_q[g*P +: P];
    end else begin : g_nokbd
      assign kbd = '0;
    end

    assign raw = joystick[g*P +: P] | kbd;

    // Coin sits at P-2; edges arriving during a running pulse are absorbed.
    always_comb begin
      coin_prev_d = raw[P-2];
      coin_start  = 1'b0;
      cnt_d       = cnt_q;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (raw[P-2] && !coin_prev_q) begin
        cnt_d      = CW'(COIN_PULSE - 1);
        coin_start = 1'b1;
      end
      out_d      = raw;
      out_d[P-2] = (cnt_q != '0) || coin_start || raw[P-2];
`ifdef AUTOFIRE_EN
      out_d[4 +: BUTTONS] = raw[4 +: BUTTONS] &
                            (~autofire_sel[g*BUTTONS +: BUTTONS] | {BUTTONS{af_phase_q}});
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q       <= '0;
        coin_prev_q <= 1'b0;
        out_q       <= '0;
      end else begin
        cnt_q       <= cnt_d;
        coin_prev_q <= coin_prev_d;
        out_q       <= out_d;
      end
    end

    assign player[g*P +: P] = out_q;
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper at PLAYERS=4, BUTTONS=6, COIN_PULSE=16, AF_PERIOD=4.
// Expected words are queued with a due cycle when stimulus is applied and compared when that cycle arrives.
module tb_arcade_input_mapper;
  localparam int PL  = 4;
  localparam int BT  = 6;
  localparam int P   = BT + 7;
  localparam int W   = PL * P;
  localparam int CP  = 16;
  localparam int AFP = 4;
  localparam logic [W-1:0] Z   = '0;
  localparam logic [W-1:0] ALL = '1;

  logic           clk_sys = 1'b0;
  logic           reset_n = 1'b1;
  logic [10:0]    ps2_key;
  logic [W-1:0]   joystick;
  logic [PL*BT-1:0] autofire_sel;
  logic [W-1:0]   player;
  logic [1:0]     service;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .PLAYERS(PL), .BUTTONS(BT), .COIN_PULSE(CP), .AF_PERIOD(AFP)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
    .autofire_sel(autofire_sel), .player(player), .service(service)
  );

  typedef struct {
    int           due;
    logic [W-1:0] exp;
    logic [W-1:0] mask;
    logic [1:0]   svc;
    string        name;
  } sb_t;

  typedef struct {
    bit           ev;
    bit           p;
    bit           e;
    logic [7:0]   code;
    logic [W-1:0] joy;
    logic [W-1:0] exp;
    logic [1:0]   svc;
    string        name;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rel_cyc = 0;
  logic tog;
  logic [W-1:0] acc;

  function automatic logic [W-1:0] b(input int pl, input int idx);
    logic [W-1:0] v;
    v = '0;
    v[pl*P+idx] = 1'b1;
    return v;
  endfunction

  task automatic push(input int lat, input logic [W-1:0] exp, input logic [W-1:0] mask,
                      input logic [1:0] svc, input string name);
    sb_t s;
    s.due = cyc + lat; s.exp = exp; s.mask = mask; s.svc = svc; s.name = name;
    sb.push_back(s);
  endtask

  task automatic check_now(input string name, input logic [W-1:0] exp, input logic [1:0] svc);
    checks++;
    if (player !== exp || service !== svc) begin
      errors++;
      $display("FAIL %s: player=%h service=%b, expected player=%h service=%b", name, player, service, exp, svc);
    end
  endtask

  task automatic tick();
    logic [W-1:0] act, ex;
    @(posedge clk_sys);
    #1;
    cyc++;
    rel_cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        act = player & sb[i].mask;
        ex  = sb[i].exp & sb[i].mask;
        checks++;
        if (act !== ex || service !== sb[i].svc) begin
          errors++;
          $display("FAIL %s (cycle %0d): player=%h service=%b, expected player=%h service=%b",
                   sb[i].name, cyc, act, service, ex, sb[i].svc);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic ps2_event(input bit p, input bit e, input logic [7:0] code);
    tog = ~tog;
    ps2_key = {tog, p, e, code};
  endtask

  task automatic add(input bit ev, input bit p, input bit e, input logic [7:0] code,
                     input logic [W-1:0] joy, input logic [W-1:0] exp, input logic [1:0] svc,
                     input string name);
    vec_t v;
    v.ev = ev; v.p = p; v.e = e; v.code = code; v.joy = joy; v.exp = exp; v.svc = svc; v.name = name;
    vt.push_back(v);
  endtask

  initial begin
    logic [7:0] rel_codes[11];
    bit         rel_ext[11];
    bit         ph;

    // Vector table: keyboard state accumulates from row to row.
    add(1, 1, 1, 8'h75, Z, b(0,3), 2'b00, "p1_up_press");
    add(1, 0, 1, 8'h75, Z, Z, 2'b00, "p1_up_release");
    add(1, 1, 0, 8'h75, Z, Z, 2'b00, "keypad8_ignored");
    add(1, 0, 0, 8'h75, Z, Z, 2'b00, "keypad8_release");
    add(1, 1, 1, 8'h74, Z, b(0,0), 2'b00, "p1_right_press");
    add(1, 0, 0, 8'h74, Z, b(0,0), 2'b00, "right_rel_no_ext");
    add(1, 0, 1, 8'h74, Z, Z, 2'b00, "p1_right_release");
    add(1, 1, 0, 8'h14, Z, b(0,4), 2'b00, "lctrl_press");
    add(1, 0, 1, 8'h14, Z, Z, 2'b00, "rctrl_release");
    add(1, 1, 1, 8'h14, Z, b(0,4), 2'b00, "rctrl_press");
    add(1, 0, 0, 8'h14, Z, Z, 2'b00, "lctrl_release");
    add(1, 1, 0, 8'h29, Z, b(0,6), 2'b00, "space_press");
    add(1, 1, 0, 8'h15, Z, b(0,6)|b(1,6), 2'b00, "p2_q_press");
    add(1, 1, 0, 8'h15, Z, b(0,6)|b(1,6), 2'b00, "p2_q_repeat");
    add(1, 1, 0, 8'h34, Z, b(0,6)|b(1,6)|b(1,0), 2'b00, "p2_right_press");
    add(1, 1, 0, 8'h1A, Z, b(0,6)|b(1,6)|b(1,0), 2'b00, "unmapped_code");
    add(1, 1, 0, 8'h46, Z, b(0,6)|b(1,6)|b(1,0), 2'b01, "svc9_press");
    add(1, 1, 0, 8'h45, Z, b(0,6)|b(1,6)|b(1,0), 2'b11, "svc0_press");
    add(0, 0, 0, 8'h00, b(3,9), b(0,6)|b(1,6)|b(1,0)|b(3,9), 2'b11, "p4_fire5_joy");
    add(0, 0, 0, 8'h00, b(0,6), b(0,6)|b(1,6)|b(1,0), 2'b11, "joy_or_key_same_bit");
    add(1, 0, 0, 8'h29, b(0,6), b(0,6)|b(1,6)|b(1,0), 2'b11, "space_rel_joy_held");
    add(1, 0, 0, 8'h15, Z, b(1,0), 2'b11, "p2_q_release");
    add(1, 0, 0, 8'h34, Z, Z, 2'b11, "p2_right_release");
    add(1, 0, 0, 8'h46, Z, Z, 2'b10, "svc9_release");
    add(1, 0, 0, 8'h45, Z, Z, 2'b00, "svc0_release");
    acc = b(0,5) | b(1,3);
    add(1, 1, 0, 8'h11, b(1,3), acc, 2'b00, "alt_plus_p2_up_joy");
    acc |= b(0,12); add(1, 1, 0, 8'h4D, b(1,3), acc, 2'b00, "p1_pause");
    acc |= b(1,10); add(1, 1, 0, 8'h1E, b(1,3), acc, 2'b00, "p2_start");
    add(1, 1, 0, 8'h2D, b(1,3), acc, 2'b00, "p2_up_key_and_joy");
    acc |= b(1,1);  add(1, 1, 0, 8'h23, b(1,3), acc, 2'b00, "p2_left");
    acc |= b(1,2);  add(1, 1, 0, 8'h2B, b(1,3), acc, 2'b00, "p2_down");
    acc |= b(1,4);  add(1, 1, 0, 8'h1C, b(1,3), acc, 2'b00, "p2_fire0");
    acc |= b(1,5);  add(1, 1, 0, 8'h1B, b(1,3), acc, 2'b00, "p2_fire1");
    acc |= b(0,10); add(1, 1, 0, 8'h16, b(1,3), acc, 2'b00, "p1_start");
    acc |= b(0,2);  add(1, 1, 1, 8'h72, b(1,3), acc, 2'b00, "p1_down");
    acc |= b(0,1);  add(1, 1, 1, 8'h6B, b(1,3), acc, 2'b00, "p1_left");

    rel_codes = '{8'h11, 8'h4D, 8'h1E, 8'h2D, 8'h23, 8'h2B, 8'h1C, 8'h1B, 8'h16, 8'h72, 8'h6B};
    rel_ext   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    // Reset with toggle high: priming must swallow it.
    ps2_key = {1'b1, 1'b1, 1'b1, 8'h75};
    tog = 1'b1;
    joystick = '0;
    autofire_sel = '0;
    #1 reset_n = 1'b0;
    #1 check_now("reset_state", Z, 2'b00);
    tick(); tick();
    check_now("reset_held", Z, 2'b00);
    reset_n = 1'b1;
    rel_cyc = 0;
    for (int k = 1; k <= 8; k++) push(k, Z, ALL, 2'b00, "prime_no_event");
    repeat (8) tick();

    // Exact latencies: key 2 cycles, joystick 1 cycle.
    ps2_event(1'b1, 1'b1, 8'h75);
    push(1, Z, ALL, 2'b00, "key_lat_cycle1");
    push(2, b(0,3), ALL, 2'b00, "key_lat_cycle2");
    tick(); tick();
    ps2_event(1'b0, 1'b1, 8'h75);
    push(1, b(0,3), ALL, 2'b00, "key_rel_cycle1");
    push(2, Z, ALL, 2'b00, "key_rel_cycle2");
    tick(); tick();
    joystick = b(1,0);
    push(1, b(1,0), ALL, 2'b00, "joy_lat_cycle1");
    tick();
    joystick = Z;
    push(1, Z, ALL, 2'b00, "joy_release_cycle1");
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].ev) ps2_event(vt[i].p, vt[i].e, vt[i].code);
      joystick = vt[i].joy;
      push(2, vt[i].exp, ALL, vt[i].svc, vt[i].name);
      tick(); tick();
    end

    joystick = Z;
    for (int i = 0; i < 11; i++) begin
      ps2_event(1'b0, rel_ext[i], rel_codes[i]);
      if (i == 10) push(2, Z, ALL, 2'b00, "release_all");
      tick(); tick();
    end

    // Single-cycle coin, re-triggered at cycle 5: exactly 16 cycles high.
    joystick = b(0,11);
    for (int k = 1; k <= 20; k++) push(k, (k <= CP) ? b(0,11) : Z, ALL, 2'b00, "coin_stretch");
    tick();
    joystick = Z;
    tick(); tick(); tick();
    joystick = b(0,11);
    tick();
    joystick = Z;
    repeat (15) tick();

    // Held coin on P3 stays high throughout, drops one cycle after release.
    joystick = b(2,11);
    push(1, b(2,11), ALL, 2'b00, "coin_held_start");
    push(20, b(2,11), ALL, 2'b00, "coin_held_mid");
    push(30, b(2,11), ALL, 2'b00, "coin_held_end");
    repeat (30) tick();
    joystick = Z;
    push(1, Z, ALL, 2'b00, "coin_held_release");
    tick();

    // Reset mid-operation clears key state; re-priming ignores the stale toggle.
    ps2_event(1'b1, 1'b1, 8'h75);
    push(2, b(0,3), ALL, 2'b00, "pre_reset_key");
    tick(); tick();
    reset_n = 1'b0;
    #2 check_now("mid_reset_clear", Z, 2'b00);
    tick();
    reset_n = 1'b1;
    rel_cyc = 0;
    for (int k = 1; k <= 3; k++) push(k, Z, ALL, 2'b00, "post_reset_reprime");
    repeat (3) tick();

    // Autofire on P1 fire0 only; P2 fire0 held without select.
    joystick = b(0,4) | b(1,4);
    autofire_sel = '0;
    autofire_sel[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
`ifdef AUTOFIRE_EN
      ph = (((rel_cyc + k - 1) / AFP) % 2) == 0;
`else
      ph = 1'b1;
`endif
      push(k, (ph ? b(0,4) : Z) | b(1,4), ALL, 2'b00, "autofire");
    end
    repeat (16) tick();
    joystick = Z;
    autofire_sel = '0;
    tick(); tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
